// File: rtl/neosd_cmd_sched.sv
// Command scheduler for the NEOSD CMD-line engine.
// Two requesters (0 = CPU register path, 1 = auto CMD12/CMD13 source) share
// one engine. Round-robin grant, tick-paced commit handshake, response
// timeout, abort handling and per-requester completion status.
module neosd_cmd_sched #(
  parameter int unsigned TIMEOUT_TICKS = 64,
  parameter int unsigned CNT_W         = 8
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        en_i,
  input  logic        abort_i,
  input  logic        tick_i,
  input  logic [1:0]  rq_valid_i,
  output logic [1:0]  rq_ready_o,
  input  logic [5:0]  rq0_idx_i,
  input  logic [5:0]  rq1_idx_i,
  input  logic [31:0] rq0_arg_i,
  input  logic [31:0] rq1_arg_i,
  input  logic [6:0]  rq0_crc_i,
  input  logic [6:0]  rq1_crc_i,
  input  logic [1:0]  rq0_rmode_i,
  input  logic [1:0]  rq1_rmode_i,
  output logic        eng_commit_o,
  output logic [5:0]  eng_idx_o,
  output logic [31:0] eng_arg_o,
  output logic [6:0]  eng_crc_o,
  output logic [1:0]  eng_rmode_o,
  input  logic        eng_done_i,
  output logic        eng_abort_o,
  output logic [1:0]  cpl_valid_o,
  output logic [1:0]  cpl_status_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_ABORT,
    S_COMPLETE
  } state_t;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_TIMEOUT = 2'd1,
    ST_ABORTED = 2'd2
  } status_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       idx_q, idx_d;
  logic [31:0]      arg_q, arg_d;
  logic [6:0]       crc_q, crc_d;
  logic [1:0]       rmode_q, rmode_d;
  status_t          status_q, status_d;
  status_t          pend_q, pend_d;

  logic [1:0] grant;
  logic       kill;
  logic       tmo_hit;

  // Round-robin grant: a tie goes to the requester that did not win last.
  always_comb begin
    grant = rq_valid_i;
    if (rq_valid_i == 2'b11) begin
      grant = last_q ? 2'b01 : 2'b10;
    end
  end

  assign rq_ready_o = (state_q == S_IDLE && en_i && !abort_i) ? grant : 2'b00;

  assign kill = abort_i | ~en_i;
  // Counter is about to reach TIMEOUT_TICKS-1 on this tick.
  assign tmo_hit = (rmode_q != 2'd0) && tick_i && (cnt_q == CNT_W'(TIMEOUT_TICKS - 2));

  assign eng_idx_o    = idx_q;
  assign eng_arg_o    = arg_q;
  assign eng_crc_o    = crc_q;
  assign eng_rmode_o  = rmode_q;
  assign cpl_status_o = status_q;
  assign busy_o       = (state_q != S_IDLE);

  // Next-state, datapath latch and per-state strobes.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    arg_d        = arg_q;
    crc_d        = crc_q;
    rmode_d      = rmode_q;
    status_d     = status_q;
    pend_d       = pend_q;
    eng_commit_o = 1'b0;
    eng_abort_o  = 1'b0;
    cpl_valid_o  = 2'b00;
    unique case (state_q)
      S_IDLE: begin
        if (|(rq_valid_i & rq_ready_o)) begin
          owner_d = rq_ready_o[1];
          last_d  = rq_ready_o[1];
          cnt_d   = '0;
          if (rq_ready_o[1]) begin
            idx_d   = rq1_idx_i;
            arg_d   = rq1_arg_i;
            crc_d   = rq1_crc_i;
            rmode_d = rq1_rmode_i;
          end else begin
            idx_d   = rq0_idx_i;
            arg_d   = rq0_arg_i;
            crc_d   = rq0_crc_i;
            rmode_d = rq0_rmode_i;
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        eng_commit_o = 1'b1;
        if (kill) begin
          pend_d  = ST_ABORTED;
          state_d = S_ABORT;
        end else if (tick_i) begin
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        // Priority: done > abort/disable > timeout.
        if (eng_done_i) begin
          status_d = ST_OK;
          state_d  = S_COMPLETE;
        end else if (kill) begin
          pend_d  = ST_ABORTED;
          state_d = S_ABORT;
        end else if (rmode_q != 2'd0 && tick_i) begin
          cnt_d = cnt_q + 1'b1;
          if (tmo_hit) begin
            pend_d  = ST_TIMEOUT;
            state_d = S_ABORT;
          end
        end
      end
      S_ABORT: begin
        eng_abort_o = 1'b1;
        status_d    = pend_q;
        state_d     = S_COMPLETE;
      end
      S_COMPLETE: begin
        cpl_valid_o = owner_q ? 2'b10 : 2'b01;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
      arg_q    <= '0;
      crc_q    <= '0;
      rmode_q  <= '0;
      status_q <= ST_OK;
      pend_q   <= ST_OK;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      arg_q    <= arg_d;
      crc_q    <= crc_d;
      rmode_q  <= rmode_d;
      status_q <= status_d;
      pend_q   <= pend_d;
    end
  end

endmodule

// File: tb/tb_neosd_cmd_sched.sv
// Testbench for neosd_cmd_sched: vector table for the IDLE grant logic,
// directed sequences for the multi-cycle corners, and random transactions
// checked against a transaction-level outcome model.
module tb_neosd_cmd_sched;

  localparam int TT  = 4;
  localparam int INF = 100000;

  logic        clk;
  logic        rstn_i, en_i, abort_i, tick_i;
  logic [1:0]  rq_valid_i, rq_ready_o;
  logic [5:0]  rq0_idx_i, rq1_idx_i;
  logic [31:0] rq0_arg_i, rq1_arg_i;
  logic [6:0]  rq0_crc_i, rq1_crc_i;
  logic [1:0]  rq0_rmode_i, rq1_rmode_i;
  logic        eng_commit_o, eng_done_i, eng_abort_o, busy_o;
  logic [5:0]  eng_idx_o;
  logic [31:0] eng_arg_o;
  logic [6:0]  eng_crc_o;
  logic [1:0]  eng_rmode_o, cpl_valid_o, cpl_status_o;

  neosd_cmd_sched #(.TIMEOUT_TICKS(TT), .CNT_W(8)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .en_i(en_i), .abort_i(abort_i), .tick_i(tick_i),
    .rq_valid_i(rq_valid_i), .rq_ready_o(rq_ready_o),
    .rq0_idx_i(rq0_idx_i), .rq1_idx_i(rq1_idx_i),
    .rq0_arg_i(rq0_arg_i), .rq1_arg_i(rq1_arg_i),
    .rq0_crc_i(rq0_crc_i), .rq1_crc_i(rq1_crc_i),
    .rq0_rmode_i(rq0_rmode_i), .rq1_rmode_i(rq1_rmode_i),
    .eng_commit_o(eng_commit_o), .eng_idx_o(eng_idx_o), .eng_arg_o(eng_arg_o),
    .eng_crc_o(eng_crc_o), .eng_rmode_o(eng_rmode_o), .eng_done_i(eng_done_i),
    .eng_abort_o(eng_abort_o), .cpl_valid_o(cpl_valid_o),
    .cpl_status_o(cpl_status_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state: last winner and last reported status.
  int m_last   = 1;
  int m_status = 0;

  bit tick_pat [256];

  typedef struct {
    logic       en;
    logic       ab;
    logic [1:0] vld;
    logic [1:0] exp_rdy;
  } vec_t;
  vec_t tv [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_ticks(input int period, input int phase);
    for (int c = 0; c < 256; c++) tick_pat[c] = ((c % period) == phase);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn_i = 1'b0; en_i = 1'b1; abort_i = 1'b0; tick_i = 1'b0;
    eng_done_i = 1'b0; rq_valid_i = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rstn_i = 1'b1;
    m_last = 1;
    m_status = 0;
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_commit", eng_commit_o, 0);
    chk("rst_eng_abort", eng_abort_o, 0);
    chk("rst_cpl_valid", cpl_valid_o, 0);
    chk("rst_cpl_status", cpl_status_o, 0);
    chk("rst_payload", {eng_idx_o, eng_arg_o, eng_crc_o, eng_rmode_o}, 0);
  endtask

  // One command from acceptance to completion. Offset 0 is the first
  // cycle after acceptance; done/abort offsets are relative to it.
  task automatic run_txn(input logic [1:0] vld, input logic [1:0] rm, input int done_at,
                         input int abort_at, input bit by_en, input bit rand_pl);
    int g, ft, bs, dt, at, tt, n, fin, st, cc, commit_last;
    logic [1:0]  gmask;
    logic [46:0] exp_pl;

    g = (vld == 2'b11) ? (m_last == 1 ? 0 : 1) : (vld[1] ? 1 : 0);
    gmask = (g == 1) ? 2'b10 : 2'b01;

    // Outcome prediction: earliest terminating event wins, ties resolved
    // done > abort > timeout; an abort before BUSY ends the issue phase.
    ft = -1;
    for (int c = 0; c < 256; c++) if (tick_pat[c] && ft < 0) ft = c;
    if (ft < 0) begin
      $display("FAIL model_tick: no tick in pattern");
      errors++;
      return;
    end
    if (abort_at >= 0 && abort_at <= ft) begin
      fin = abort_at; st = 2; commit_last = abort_at;
    end else begin
      bs = ft + 1;
      commit_last = ft;
      dt = (done_at >= bs) ? done_at : INF;
      at = (abort_at >= bs) ? abort_at : INF;
      tt = INF;
      if (rm != 2'd0) begin
        n = 0;
        for (int c = bs; c < 256; c++) begin
          if (tick_pat[c]) n++;
          if (n == TT - 1) begin tt = c; break; end
        end
      end
      fin = dt;
      if (at < fin) fin = at;
      if (tt < fin) fin = tt;
      st = (dt == fin) ? 0 : ((at == fin) ? 2 : 1);
    end
    if (fin > 250) begin
      $display("FAIL model_bound: transaction never terminates");
      errors++;
      $fatal(1, "unterminated transaction");
    end
    cc = fin + ((st == 0) ? 1 : 2);

    // IDLE cycle: request and accept.
    @(negedge clk);
    rq_valid_i = vld; en_i = 1'b1; abort_i = 1'b0;
    tick_i = 1'($urandom); eng_done_i = 1'($urandom);
    rq0_rmode_i = rm; rq1_rmode_i = rm;
    if (rand_pl) begin
      rq0_idx_i = 6'($urandom); rq0_arg_i = $urandom; rq0_crc_i = 7'($urandom);
      rq1_idx_i = 6'($urandom); rq1_arg_i = $urandom; rq1_crc_i = 7'($urandom);
    end
    exp_pl = (g == 1) ? {rq1_idx_i, rq1_arg_i, rq1_crc_i, rq1_rmode_i}
                      : {rq0_idx_i, rq0_arg_i, rq0_crc_i, rq0_rmode_i};
    #1;
    chk("idle_busy", busy_o, 0);
    chk("grant", rq_ready_o, gmask);
    chk("idle_status_hold", cpl_status_o, m_status);

    for (int c = 0; c <= cc; c++) begin
      @(negedge clk);
      tick_i     = tick_pat[c];
      eng_done_i = (c == done_at);
      abort_i    = (!by_en && c == abort_at);
      en_i       = !(by_en && c == abort_at);
      rq_valid_i = (c == cc) ? 2'b00 : 2'($urandom);
      rq0_idx_i = 6'($urandom); rq0_arg_i = $urandom; rq0_crc_i = 7'($urandom);
      rq1_idx_i = 6'($urandom); rq1_arg_i = $urandom; rq1_crc_i = 7'($urandom);
      rq0_rmode_i = 2'($urandom); rq1_rmode_i = 2'($urandom);
      #1;
      chk("busy", busy_o, 1);
      chk("ready_in_op", rq_ready_o, 0);
      chk("payload", {17'd0, eng_idx_o, eng_arg_o, eng_crc_o, eng_rmode_o}, {17'd0, exp_pl});
      chk("commit", eng_commit_o, (c <= commit_last));
      chk("eng_abort", eng_abort_o, (st != 0 && c == fin + 1));
      chk("cpl_valid", cpl_valid_o, (c == cc) ? gmask : 2'b00);
      chk("cpl_status", cpl_status_o, (c == cc) ? st : m_status);
    end
    abort_i = 1'b0; en_i = 1'b1; eng_done_i = 1'b0;
    m_last = g;
    m_status = st;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn_i = 1'b0; en_i = 1'b1; abort_i = 1'b0; tick_i = 1'b0; eng_done_i = 1'b0;
    rq_valid_i = 2'b00;
    rq0_idx_i = '0; rq1_idx_i = '0; rq0_arg_i = '0; rq1_arg_i = '0;
    rq0_crc_i = '0; rq1_crc_i = '0; rq0_rmode_i = '0; rq1_rmode_i = '0;

    tv[0] = '{1'b1, 1'b0, 2'b00, 2'b00};
    tv[1] = '{1'b1, 1'b0, 2'b01, 2'b01};
    tv[2] = '{1'b1, 1'b0, 2'b10, 2'b10};
    tv[3] = '{1'b1, 1'b0, 2'b11, 2'b01};
    tv[4] = '{1'b0, 1'b0, 2'b11, 2'b00};
    tv[5] = '{1'b1, 1'b1, 2'b11, 2'b00};
    tv[6] = '{1'b0, 1'b1, 2'b01, 2'b00};
    tv[7] = '{1'b1, 1'b1, 2'b10, 2'b00};

    do_reset();

    // IDLE grant/ready vectors; valid is withdrawn before the edge.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      en_i = tv[i].en; abort_i = tv[i].ab; rq_valid_i = tv[i].vld;
      #1;
      chk($sformatf("vec%0d_ready", i), rq_ready_o, tv[i].exp_rdy);
      #2;
      rq_valid_i = 2'b00; en_i = 1'b1; abort_i = 1'b0;
    end

    // Single OK command.
    rq0_idx_i = 6'd8; rq0_arg_i = 32'h1AA; rq0_crc_i = 7'h43;
    set_ticks(4, 3);
    run_txn(2'b01, 2'd1, 10, -1, 1'b0, 1'b0);

    // Round-robin with both requesters always valid.
    do_reset();
    set_ticks(2, 1);
    for (int i = 0; i < 4; i++) run_txn(2'b11, 2'd0, 5, -1, 1'b0, 1'b1);

    // Timeout on the third BUSY tick.
    set_ticks(4, 3);
    run_txn(2'b01, 2'd1, -1, -1, 1'b0, 1'b1);
    // rmode=0 survives ~100 ticks, then software abort.
    set_ticks(2, 1);
    run_txn(2'b01, 2'd0, -1, 205, 1'b0, 1'b1);
    // Done on the same cycle as the timeout tick.
    set_ticks(4, 3);
    run_txn(2'b10, 2'd2, 15, -1, 1'b0, 1'b1);
    // Abort pulse in BUSY, then disable during ISSUE.
    run_txn(2'b10, 2'd1, -1, 6, 1'b0, 1'b1);
    run_txn(2'b01, 2'd1, -1, 1, 1'b1, 1'b1);
    // Disable in IDLE blocks acceptance.
    @(negedge clk);
    en_i = 1'b0; rq_valid_i = 2'b11;
    #1;
    chk("en_off_ready", rq_ready_o, 0);
    #2;
    rq_valid_i = 2'b00; en_i = 1'b1;

    // Reset mid-BUSY after requester 0 won last.
    set_ticks(4, 3);
    run_txn(2'b01, 2'd1, -1, 2, 1'b0, 1'b1);
    @(negedge clk);
    rq_valid_i = 2'b01; tick_i = 1'b0;
    @(negedge clk);
    rq_valid_i = 2'b00; tick_i = 1'b1;
    @(negedge clk);
    tick_i = 1'b0;
    #1;
    chk("pre_rst_busy", busy_o, 1);
    @(negedge clk);
    rstn_i = 1'b0;
    @(negedge clk);
    rstn_i = 1'b1;
    #1;
    chk("midrst_busy", busy_o, 0);
    chk("midrst_commit", eng_commit_o, 0);
    chk("midrst_abort", eng_abort_o, 0);
    chk("midrst_status", cpl_status_o, 0);
    chk("midrst_ready", rq_ready_o, 0);
    for (int i = 0; i < 3; i++) begin
      chk("midrst_no_cpl", cpl_valid_o, 0);
      @(negedge clk);
      #1;
    end
    m_last = 1;
    m_status = 0;
    set_ticks(2, 1);
    run_txn(2'b11, 2'd0, 4, -1, 1'b0, 1'b1);

    // Random transactions.
    for (int t = 0; t < 40; t++) begin
      logic [1:0] v;
      int d, a;
      v = 2'($urandom_range(1, 3));
      for (int c = 0; c < 256; c++) tick_pat[c] = ($urandom_range(0, 2) == 0);
      tick_pat[$urandom_range(0, 11)] = 1'b1;
      d = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 30));
      a = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 60)) : 120;
      run_txn(v, 2'($urandom_range(0, 2)), d, a, 1'($urandom), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/neosd_cmd_sched.md
Name: neosd_cmd_sched

Overview:
- Command scheduler in front of the NEOSD CMD-line engine.
- Shares the single engine between two requesters: requester 0 is the CPU register path, requester 1 is the hardware auto-command source (CMD12/CMD13).
- Arbitrates round-robin, hands the command to the engine via a commit/done handshake paced by the SD clock-enable tick, and enforces a response timeout.
- Returns a completion status to the requester that issued the command.

Parameters:
TIMEOUT_TICKS, 64, number of tick_i pulses allowed in BUSY before a response timeout (minimum 2)
CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_TICKS

Ports:
clk_i  in  1  system clock
rstn_i  in  1  reset, synchronous, active-low
en_i  in  1  controller enable (CTRL.EN)
abort_i  in  1  software abort request (CTRL.ABRT), level
tick_i  in  1  one-cycle SD bit-clock enable, same pulse that paces the engine
rq_valid_i  in  2  per-requester command valid
rq_ready_o  out  2  per-requester accept
rq0_idx_i, rq1_idx_i  in  6  command index
rq0_arg_i, rq1_arg_i  in  32  command argument
rq0_crc_i, rq1_crc_i  in  7  CRC7 of command
rq0_rmode_i, rq1_rmode_i  in  2  response mode: 0 none, 1 short, 2 long
eng_commit_o  out  1  commit to engine
eng_idx_o  out  6  latched index
eng_arg_o  out  32  latched argument
eng_crc_o  out  7  latched CRC
eng_rmode_o  out  2  latched response mode
eng_done_i  in  1  engine command-done pulse
eng_abort_o  out  1  engine abort pulse
cpl_valid_o  out  2  one-cycle completion strobe, one bit per requester
cpl_status_o  out  2  0 OK, 1 TIMEOUT, 2 ABORTED; valid with cpl_valid_o
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk_i. rstn_i is synchronous and active-low.
- Values in reset:
  - state IDLE
  - eng_commit_o, eng_abort_o, cpl_valid_o, cpl_status_o, busy_o = 0
  - last_grant = 1, so the CPU wins the first tie
  - timeout counter = 0
  - latched payload = 0
- A reset taken mid-operation drops the in-flight command silently. No completion strobe is produced.

- IDLE:
  - Grant is combinational. Only one valid: that requester is granted. Both valid: the requester != last_grant is granted.
  - rq_ready_o[r] = (state==IDLE) & en_i & ~abort_i & grant[r].
  - On valid&ready: latch that requester's payload into eng_*, store r, set last_grant=r, clear the counter, go to ISSUE.
  - rq_ready_o is 0 in all other states.
- ISSUE:
  - eng_commit_o = 1 and held until a cycle with tick_i=1; that cycle is the engine's sampling point.
  - On that cycle go to BUSY. eng_commit_o is 0 from the next cycle.
- BUSY:
  - eng_done_i=1 -> COMPLETE with status OK.
  - Otherwise, if rmode!=0 and tick_i=1: counter+1.
  - If the counter reaches TIMEOUT_TICKS-1 on a tick -> ABORT with status TIMEOUT.
  - rmode=0 never times out.
  - eng_done_i and timeout in the same cycle: done wins (OK).
- Abort (applies in ISSUE or BUSY):
  - abort_i=1 or en_i=0 -> ABORT with status ABORTED.
  - It takes precedence over timeout but not over eng_done_i.
- ABORT:
  - eng_abort_o = 1 for exactly one cycle.
  - Then go to COMPLETE.
- COMPLETE:
  - cpl_valid_o[stored r] = 1 for one cycle, with cpl_status_o.
  - Next cycle go to IDLE; cpl_status_o holds its value until the next completion.
- eng_done_i outside BUSY is ignored.
- The latched eng_* payload is stable from ISSUE through COMPLETE. Requester inputs may change after acceptance.
- Back-to-back operation:
  - Minimum IDLE->IDLE turnaround is 4 cycles: IDLE, ISSUE (tick present), BUSY (done), COMPLETE.
  - A new grant can occur in the IDLE cycle immediately after COMPLETE.

Test Plan:
- Single OK command: reset; rq_valid_i=01, idx=8, arg=0x1AA, rmode=1; tick every 4 cycles; eng_done_i 10 cycles after commit -> rq_ready_o[0] 1 cycle; eng_idx_o=8, eng_arg_o=0x000001AA; eng_commit_o high until the first tick; cpl_valid_o=01, status 0.
- Round-robin: both valid continuously, rmode=0, done returned each time -> grant order 0,1,0,1. Each cpl_valid_o bit matches its requester.
- Timeout: TIMEOUT_TICKS=4, rmode=1, no done -> after the 3rd tick in BUSY, eng_abort_o 1 cycle; cpl_valid_o=01, status 1. rmode=0 with no done stays in BUSY for 100 ticks with no timeout.
- Done/timeout collision: eng_done_i on the same cycle as the timeout tick -> status 0; eng_abort_o never asserted.
- Abort: abort_i pulsed in BUSY -> eng_abort_o next cycle, then status 2 to the owner. The same with en_i=0 during ISSUE. en_i=0 in IDLE -> rq_ready_o=00.
- Reset mid-BUSY: rstn_i low 1 cycle -> all outputs 0 the next cycle, no cpl_valid_o pulse; a subsequent tie is granted to requester 0.
